// File: rtl/relu_backward_ctrl.sv
// Job controller for a fixed-latency ReLU-backward datapath: issues vectors under a FIFO credit limit and drains results in order.
// Define RELU_BWD_CTRL_STALL_CNT_EN to add the saturating stall_cycles counter output.
module relu_backward_ctrl #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         num_vecs,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WIDTH-1:0] in_vec,
    output logic [32*WIDTH-1:0] dp_in_vec,
    input  logic [32*WIDTH-1:0] dp_out_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WIDTH-1:0] out_vec,
    output logic                busy,
    output logic                done
`ifdef RELU_BWD_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         num_vecs_q, num_vecs_d;
    logic [15:0]         issued_q, issued_d;
    logic [15:0]         retired_q, retired_d;
    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [32*WIDTH-1:0] dp_in_vec_q, dp_in_vec_d;
    logic [32*WIDTH-1:0] mem_q [DEPTH];

    logic                start_ok;
    logic                issue;
    logic                fifo_wr;
    logic                fifo_rd;
    logic [CNT_W:0]      credit_used;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            num_vecs_q   <= '0;
            issued_q     <= '0;
            retired_q    <= '0;
            vld_q        <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dp_in_vec_q  <= '0;
        end else begin
            state_q      <= state_d;
            num_vecs_q   <= num_vecs_d;
            issued_q     <= issued_d;
            retired_q    <= retired_d;
            vld_q        <= vld_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dp_in_vec_q  <= dp_in_vec_d;
        end
    end

    // Result storage carries no reset; occupancy is governed solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= dp_out_vec;
        end
    end

    // DRAIN finishes on the cycle the last retire happens, so done follows it by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_vecs == 16'd0) ? DONE : RUN;
            RUN:     if (issued_q == num_vecs_q) state_d = DRAIN;
            DRAIN:   if (retired_d == num_vecs_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Vectors in the datapath already own a FIFO slot, so the no-stall datapath can never overflow it.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
        in_ready    = (state_q == RUN) && (issued_q < num_vecs_q) && (credit_used < DEPTH_C);
        out_valid   = (fifo_count_q != '0);
        out_vec     = out_valid ? mem_q[rd_ptr_q] : '0;
        dp_in_vec   = dp_in_vec_q;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
    end

    always_comb begin
        start_ok     = start && (state_q == IDLE);
        issue        = in_valid && in_ready;
        fifo_wr      = vld_q[LATENCY-1];
        fifo_rd      = out_valid && out_ready;
        num_vecs_d   = start_ok ? num_vecs : num_vecs_q;
        issued_d     = start_ok ? 16'd0 : issued_q + 16'(issue);
        retired_d    = start_ok ? 16'd0 : retired_q + 16'(fifo_rd);
        vld_d        = vld_q << 1;
        vld_d[0]     = issue;
        inflight_d   = inflight_q + CNT_W'(issue) - CNT_W'(fifo_wr);
        fifo_count_d = fifo_count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
        wr_ptr_d     = wr_ptr_q + PTR_W'(fifo_wr);
        rd_ptr_d     = rd_ptr_q + PTR_W'(fifo_rd);
        dp_in_vec_d  = issue ? in_vec : dp_in_vec_q;
    end

`ifdef RELU_BWD_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (start_ok) begin
            stall_cycles_d = '0;
        end else if (busy && out_valid && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_relu_backward_ctrl.sv
// Directed bench for relu_backward_ctrl with a combinational ReLU-backward datapath model (LATENCY=1).
module tb_relu_backward_ctrl;

    localparam int WIDTH   = 4;
    localparam int LATENCY = 1;
    localparam int DEPTH   = 4;
    localparam int VW      = 32 * WIDTH;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic [15:0]   num_vecs  = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [VW-1:0] in_vec    = '0;
    logic [VW-1:0] dp_in_vec, dp_out_vec, out_vec;
    logic          in_ready, out_valid, busy, done;
`ifdef RELU_BWD_CTRL_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int            errors = 0;
    int            checks = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got_q[$];
    int            n_issue = 0;
    int            done_cnt, cyc, first_iss_cyc, first_ov_cyc, last_ret_cyc, done_cyc;
    logic          ir_hist   [128];
    logic          busy_hist [128];
    int            cnt_hist  [128];

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] relu_bwd(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[32*i+31]) r[32*i +: 32] = '0;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] mk_vec(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < WIDTH; i++) begin
            v[32*i +: 32] = {((k + i) % 3 == 0), 31'(k * 65536 + i)};
        end
        return v;
    endfunction

    assign dp_out_vec = relu_bwd(dp_in_vec);

    relu_backward_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .dp_in_vec(dp_in_vec), .dp_out_vec(dp_out_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .busy(busy), .done(done)
`ifdef RELU_BWD_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        done_cnt = 0; cyc = 0;
        first_iss_cyc = -1; first_ov_cyc = -1; last_ret_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 128; i++) begin
            ir_hist[i] = 1'b0; busy_hist[i] = 1'b0; cnt_hist[i] = 0;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then record what the next rising edge will accept.
    task automatic step(input logic st, input logic [15:0] nv, input logic iv, input logic ordy);
        @(negedge clk);
        start = st; num_vecs = nv; in_valid = iv; out_ready = ordy; in_vec = mk_vec(n_issue);
        #1;
        if (cyc < 128) begin
            ir_hist[cyc] = in_ready; busy_hist[cyc] = busy; cnt_hist[cyc] = int'(dut.fifo_count_q);
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(relu_bwd(in_vec)); n_issue++;
            if (first_iss_cyc < 0) first_iss_cyc = cyc;
        end
        if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid === 1'b1 && out_ready) begin got_q.push_back(out_vec); last_ret_cyc = cyc; end
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_sb();
        step(0, 16'd0, 0, 0);
        step(0, 16'd0, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (dp_in_vec !== '0) begin errors++; $display("FAIL rst_dp_in_vec: got %h expected 0", dp_in_vec); end
`ifdef RELU_BWD_CTRL_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cycles); end
`endif
        reset = 1'b1;
        step(0, 16'd0, 0, 1);
    endtask

    task automatic test_basic();
        clear_sb();
        n_issue = 0;
        step(1, 16'd8, 1, 1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) step(0, 16'd0, 1, 1);
        step(0, 16'd0, 0, 1);
        checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== 128'h00000000_00000002_00000001_00000000) begin
                errors++; $display("FAIL basic_first: got %h expected 00000000000000020000000100000000", got_q[0]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL basic_done_cyc: got %0d expected 11", done_cyc); end
        checks++; if (done_cyc !== last_ret_cyc + 1) begin errors++; $display("FAIL basic_done_after_retire: got %0d expected %0d", done_cyc, last_ret_cyc + 1); end
        checks++; if (first_ov_cyc - first_iss_cyc !== LATENCY + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first_ov_cyc - first_iss_cyc, LATENCY + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int c;
        clear_sb();
        step(1, 16'd16, 1, 1);
        for (int k = 0; k < 120 && done_cnt == 0; k++) begin
            c = cyc;
            step(0, 16'd0, 1, !(c >= 3 && c <= 20));
        end
        checks++; if (ir_hist[4] !== 1'b1) begin errors++; $display("FAIL bp_ready_c4: got %b expected 1", ir_hist[4]); end
        checks++; if (ir_hist[5] !== 1'b0) begin errors++; $display("FAIL bp_ready_c5: got %b expected 0", ir_hist[5]); end
        checks++; if (ir_hist[20] !== 1'b0) begin errors++; $display("FAIL bp_ready_c20: got %b expected 0", ir_hist[20]); end
        checks++; if (ir_hist[22] !== 1'b1) begin errors++; $display("FAIL bp_ready_c22: got %b expected 1", ir_hist[22]); end
        checks++; if (cnt_hist[20] !== 4) begin errors++; $display("FAIL bp_fifo_full: got %0d expected 4", cnt_hist[20]); end
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
`ifdef RELU_BWD_CTRL_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'd18) begin errors++; $display("FAIL bp_stall: got %0d expected 18", stall_cycles); end
`endif
    endtask

    task automatic test_empty();
        int ir_any;
        clear_sb();
        step(1, 16'd0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 16'd0, 1, 1);
        ir_any = 0;
        for (int i = 0; i < 4; i++) ir_any += int'(ir_hist[i]);
        checks++; if (ir_any !== 0) begin errors++; $display("FAIL empty_in_ready: got %0d cycles expected 0", ir_any); end
        checks++; if (busy_hist[1] !== 1'b1) begin errors++; $display("FAIL empty_busy_c1: got %b expected 1", busy_hist[1]); end
        checks++; if (busy_hist[2] !== 1'b0) begin errors++; $display("FAIL empty_busy_c2: got %b expected 0", busy_hist[2]); end
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty_done_cyc: got %0d expected 1", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        int c;
        clear_sb();
        step(1, 16'd12, 1, 1);
        for (int k = 0; k < 80 && done_cnt == 0; k++) begin
            c = cyc;
            step(0, 16'd0, 1, !(c == 3 || c == 4));
        end
        checks++; if (cnt_hist[5] !== 3) begin errors++; $display("FAIL wrap_count_c5: got %0d expected 3", cnt_hist[5]); end
        checks++; if (cnt_hist[6] !== 3) begin errors++; $display("FAIL wrap_count_c6: got %0d expected 3", cnt_hist[6]); end
        checks++; if (got_q.size() !== 12) begin errors++; $display("FAIL wrap_count: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_midjob();
        int base;
        clear_sb();
        base = n_issue;
        step(1, 16'd10, 1, 1);
        for (int k = 0; k < 20 && n_issue - base < 5; k++) step(0, 16'd0, 1, 1);
        step(0, 16'd0, 1, 1);
        reset = 1'b0;
        step(0, 16'd0, 1, 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        checks++; if (dp_in_vec !== '0) begin errors++; $display("FAIL mid_dp_in_vec: got %h expected 0", dp_in_vec); end
        checks++; if (out_vec !== '0) begin errors++; $display("FAIL mid_out_vec: got %h expected 0", out_vec); end
        reset = 1'b1;
        clear_sb();
        for (int k = 0; k < 5; k++) step(0, 16'd0, 1, 1);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_no_output: got %0d expected 0", got_q.size()); end
        clear_sb();
        step(1, 16'd3, 1, 1);
        for (int k = 0; k < 40 && done_cnt == 0; k++) step(0, 16'd0, 1, 1);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL mid_rejob_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_rejob_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mid_rejob_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        clear_sb();
        step(1, 16'd6, 1, 1);
        step(0, 16'd0, 1, 1);
        step(0, 16'd0, 1, 1);
        step(1, 16'd2, 1, 1);
        for (int k = 0; k < 50 && done_cnt == 0; k++) step(0, 16'd0, 1, 1);
        step(0, 16'd0, 1, 1);
        checks++; if (exp_q.size() !== 6) begin errors++; $display("FAIL busy_start_issued: got %0d expected 6", exp_q.size()); end
        checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL busy_start_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_start_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_reset_midjob();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
